// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
//   state_t   : FSM encoding (ST_IDLE may issue, ST_WAIT counts latency)
//   owner_t   : which requester owns the outstanding transaction
//   mem_req_t : payload presented to the shared memory port on issue
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select between fetch and data requesters.
//   i_if_req, i_d_req : pending requests
//   i_starve_hit      : data has won STARVE_LIMIT times in a row while fetch waited
//   o_pick_if/o_pick_d: one-hot (or zero) winner
module mem_port_arbiter_arb_pick (
    input  logic i_if_req,
    input  logic i_d_req,
    input  logic i_starve_hit,
    output logic o_pick_if,
    output logic o_pick_d
);

    // Data normally wins ties; a starved fetch overrides it.
    assign o_pick_if = i_if_req & (i_starve_hit | ~i_d_req);
    assign o_pick_d  = i_d_req & ~o_pick_if;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
//   clk, reset                      : clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt        : fetch request, accepted combinationally on issue
//   if_rvalid/if_rdata              : fetch completion MEM_LAT cycles after issue
//   d_req/d_we/d_addr/d_wdata -> d_gnt : data request
//   d_rvalid/d_rdata                : data completion (rdata 0 for writes)
//   mem_en/mem_a/mem_we/mem_wd      : shared memory issue port
//   mem_rd                          : memory read data, valid MEM_LAT cycles after issue
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT      = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    state_t             r_state, w_state_nxt;
    logic [LAT_W-1:0]   r_lat, w_lat_nxt;
    logic [STV_W-1:0]   r_starve, w_starve_nxt;
    owner_t             r_owner, w_owner_nxt;
    logic               r_we, w_we_nxt;
    logic               r_cmp, w_cmp_nxt;

    logic               w_idle;
    logic               w_starve_hit;
    logic               w_pick_if;
    logic               w_pick_d;
    mem_req_t           w_win;

    // Nothing may issue during the reset cycle.
    assign w_idle       = (r_state == ST_IDLE) && !reset;
    assign w_starve_hit = (r_starve == STV_W'(STARVE_LIMIT));

    mem_port_arbiter_arb_pick u_pick (
        .i_if_req     (if_req),
        .i_d_req      (d_req),
        .i_starve_hit (w_starve_hit),
        .o_pick_if    (w_pick_if),
        .o_pick_d     (w_pick_d)
    );

    // Payload of the winning requester; fetch never writes.
    always_comb begin
        w_win = '0;
        if (w_pick_if) begin
            w_win.addr = if_addr;
        end else if (w_pick_d) begin
            w_win.we    = d_we;
            w_win.addr  = d_addr;
            w_win.wdata = d_wdata;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_lat    <= '0;
            r_starve <= '0;
            r_owner  <= OWN_IF;
            r_we     <= 1'b0;
            r_cmp    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lat    <= w_lat_nxt;
            r_starve <= w_starve_nxt;
            r_owner  <= w_owner_nxt;
            r_we     <= w_we_nxt;
            r_cmp    <= w_cmp_nxt;
        end
    end

    // Next-state and outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_lat_nxt    = r_lat;
        w_starve_nxt = r_starve;
        w_owner_nxt  = r_owner;
        w_we_nxt     = r_we;
        w_cmp_nxt    = 1'b0;
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        mem_en       = 1'b0;
        mem_a        = '0;
        mem_we       = 1'b0;
        mem_wd       = '0;

        case (r_state)
            ST_IDLE: begin
                w_lat_nxt = '0;
                if (w_idle && (w_pick_if || w_pick_d)) begin
                    if_gnt      = w_pick_if;
                    d_gnt       = w_pick_d;
                    mem_en      = 1'b1;
                    mem_a       = w_win.addr;
                    mem_we      = w_win.we;
                    mem_wd      = w_win.wdata;
                    w_owner_nxt = w_pick_if ? OWN_IF : OWN_D;
                    w_we_nxt    = w_win.we;
                    w_lat_nxt   = LAT_W'(1);
                    // A one-cycle latency completes on the very next cycle, still in IDLE.
                    if (MEM_LAT == 1) begin
                        w_cmp_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                    // Count data wins while fetch waits; any other grant clears.
                    if (w_pick_d && if_req && !w_starve_hit) begin
                        w_starve_nxt = r_starve + STV_W'(1);
                    end else begin
                        w_starve_nxt = '0;
                    end
                end
            end
            ST_WAIT: begin
                w_lat_nxt = r_lat + LAT_W'(1);
                if ((r_lat + LAT_W'(1)) == LAT_W'(MEM_LAT)) begin
                    w_state_nxt = ST_IDLE;
                    w_cmp_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Completion returned to the owner; write completions carry no data.
    always_comb begin
        if_rvalid = r_cmp && (r_owner == OWN_IF) && !reset;
        d_rvalid  = r_cmp && (r_owner == OWN_D) && !reset;
        if_rdata  = if_rvalid ? mem_rd : '0;
        d_rdata   = (d_rvalid && !r_we) ? mem_rd : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam logic [31:0] K = 32'hA5A5A5A5;
    localparam int LAT_A = 2;
    localparam int STARVE = 4;

    typedef struct packed {
        logic        if_gnt;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        d_gnt;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        mem_en;
        logic [31:0] mem_a;
        logic        mem_we;
        logic [31:0] mem_wd;
    } obs_t;

    typedef struct {
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dd;
        obs_t        exp;
    } vec_t;

    logic clk, reset;
    logic if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;

    logic if_gnt_a, if_rvalid_a, d_gnt_a, d_rvalid_a, mem_en_a, mem_we_a;
    logic [31:0] if_rdata_a, d_rdata_a, mem_a_a, mem_wd_a, mem_rd_a;
    logic if_gnt_b, if_rvalid_b, d_gnt_b, d_rvalid_b, mem_en_b, mem_we_b;
    logic [31:0] if_rdata_b, d_rdata_b, mem_a_b, mem_wd_b, mem_rd_b;

    obs_t obs_a, obs_b;
    int checks, errors;

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_LIMIT(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a),
        .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
        .mem_en(mem_en_a), .mem_a(mem_a_a), .mem_we(mem_we_a), .mem_wd(mem_wd_a),
        .mem_rd(mem_rd_a)
    );

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_b),
        .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
        .mem_en(mem_en_b), .mem_a(mem_a_b), .mem_we(mem_we_b), .mem_wd(mem_wd_b),
        .mem_rd(mem_rd_b)
    );

    assign obs_a = {if_gnt_a, if_rvalid_a, if_rdata_a, d_gnt_a, d_rvalid_a, d_rdata_a,
                    mem_en_a, mem_a_a, mem_we_a, mem_wd_a};
    assign obs_b = {if_gnt_b, if_rvalid_b, if_rdata_b, d_gnt_b, d_rvalid_b, d_rdata_b,
                    mem_en_b, mem_a_b, mem_we_b, mem_wd_b};

    // Memory models: return issued address ^ K after the configured latency.
    logic [31:0] pa0, pa1, pb0;
    always @(posedge clk) begin
        pa0 <= mem_en_a ? mem_a_a : 32'h0BAD0BAD;
        pa1 <= pa0;
        pb0 <= mem_en_b ? mem_a_b : 32'h0BAD0BAD;
    end
    assign mem_rd_a = pa1 ^ K;
    assign mem_rd_b = pb0 ^ K;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rst, input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
        input logic gi, input logic vi, input logic [31:0] rdi,
        input logic gd, input logic vd, input logic [31:0] rdd,
        input logic en, input logic [31:0] ma, input logic we, input logic [31:0] wd);
        vec_t r;
        r.rst = rst; r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw; r.da = da; r.dd = dd;
        r.exp = {gi, vi, rdi, gd, vd, rdd, en, ma, we, wd};
        return r;
    endfunction

    task automatic apply(input vec_t r, input bit sel_b, input string nm);
        @(negedge clk);
        reset = r.rst; if_req = r.ir; if_addr = r.ia;
        d_req = r.dr; d_we = r.dw; d_addr = r.da; d_wdata = r.dd;
        #1;
        chk(nm, sel_b ? obs_b : obs_a, r.exp);
    endtask

    // Reference model (DUT A): transaction bookkeeping by absolute cycle numbers.
    int          m_cyc, m_free, m_done, m_starve;
    bit          m_own_if, m_we;
    logic [31:0] m_addr;

    task automatic model_cycle(output obs_t e);
        bit idle, pf, pd;
        e = '0;
        if (!reset && m_done == m_cyc) begin
            if (m_own_if) begin
                e.if_rvalid = 1'b1; e.if_rdata = m_addr ^ K;
            end else begin
                e.d_rvalid = 1'b1; e.d_rdata = m_we ? 32'h0 : (m_addr ^ K);
            end
        end
        idle = !reset && (m_cyc >= m_free);
        pf = idle && if_req && (m_starve >= STARVE || !d_req);
        pd = idle && d_req && !pf;
        if (pf) begin
            e.if_gnt = 1'b1; e.mem_en = 1'b1; e.mem_a = if_addr;
            m_own_if = 1'b1; m_we = 1'b0; m_addr = if_addr; m_starve = 0;
        end else if (pd) begin
            e.d_gnt = 1'b1; e.mem_en = 1'b1; e.mem_a = d_addr;
            e.mem_we = d_we; e.mem_wd = d_wdata;
            m_own_if = 1'b0; m_we = d_we; m_addr = d_addr;
            m_starve = if_req ? m_starve + 1 : 0;
        end
        if (pf || pd) begin
            m_free = m_cyc + LAT_A;
            m_done = m_cyc + LAT_A;
        end
        if (reset) begin
            m_free = 0; m_done = -1; m_starve = 0;
        end
        m_cyc++;
    endtask

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    initial begin
        obs_t e, prev;
        int nd, ni;
        logic [11:0] pat;

        checks = 0; errors = 0;
        clk = 0; reset = 1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;

        // rst ir ia dr dw da dd | gi vi rdi gd vd rdd en ma we wd
        tbl_a.push_back(mk(1,0,0, 0,0,0,0,  0,0,0, 0,0,0, 0,0,0,0));
        tbl_a.push_back(mk(0,1,32'h100, 0,0,0,0,  1,0,0, 0,0,0, 1,32'h100,0,0));
        tbl_a.push_back(mk(0,0,0, 0,0,0,0,  0,0,0, 0,0,0, 0,0,0,0));
        tbl_a.push_back(mk(0,0,0, 0,0,0,0,  0,1,32'hA5A5A4A5, 0,0,0, 0,0,0,0));
        tbl_a.push_back(mk(0,1,32'h200, 1,0,32'h40,0,  0,0,0, 1,0,0, 1,32'h40,0,0));
        tbl_a.push_back(mk(0,1,32'h200, 0,0,0,0,  0,0,0, 0,0,0, 0,0,0,0));
        tbl_a.push_back(mk(0,1,32'h200, 0,0,0,0,  1,0,0, 0,1,32'hA5A5A5E5, 1,32'h200,0,0));
        tbl_a.push_back(mk(0,0,0, 0,0,0,0,  0,0,0, 0,0,0, 0,0,0,0));
        tbl_a.push_back(mk(0,0,0, 0,0,0,0,  0,1,32'hA5A5A7A5, 0,0,0, 0,0,0,0));
        tbl_a.push_back(mk(0,0,0, 1,1,32'h80,32'h1234,  0,0,0, 1,0,0, 1,32'h80,1,32'h1234));
        tbl_a.push_back(mk(0,0,0, 0,0,0,0,  0,0,0, 0,0,0, 0,0,0,0));
        tbl_a.push_back(mk(0,0,0, 0,0,0,0,  0,0,0, 0,1,0, 0,0,0,0));
        tbl_a.push_back(mk(0,0,0, 1,0,32'hC0,0,  0,0,0, 1,0,0, 1,32'hC0,0,0));
        tbl_a.push_back(mk(1,0,0, 0,0,0,0,  0,0,0, 0,0,0, 0,0,0,0));
        tbl_a.push_back(mk(0,0,0, 0,0,0,0,  0,0,0, 0,0,0, 0,0,0,0));
        tbl_a.push_back(mk(0,1,32'h300, 0,0,0,0,  1,0,0, 0,0,0, 1,32'h300,0,0));
        tbl_a.push_back(mk(0,0,0, 0,0,0,0,  0,0,0, 0,0,0, 0,0,0,0));
        tbl_a.push_back(mk(0,0,0, 0,0,0,0,  0,1,32'hA5A5A6A5, 0,0,0, 0,0,0,0));

        // MEM_LAT=1: back-to-back reads at 0,4,8
        tbl_b.push_back(mk(1,0,0, 0,0,0,0,  0,0,0, 0,0,0, 0,0,0,0));
        tbl_b.push_back(mk(0,0,0, 1,0,32'h0,0,  0,0,0, 1,0,0, 1,32'h0,0,0));
        tbl_b.push_back(mk(0,0,0, 1,0,32'h4,0,  0,0,0, 1,1,32'hA5A5A5A5, 1,32'h4,0,0));
        tbl_b.push_back(mk(0,0,0, 1,0,32'h8,0,  0,0,0, 1,1,32'hA5A5A5A1, 1,32'h8,0,0));
        tbl_b.push_back(mk(0,0,0, 0,0,0,0,  0,0,0, 0,1,32'hA5A5A5AD, 0,0,0,0));

        foreach (tbl_a[i]) apply(tbl_a[i], 1'b0, $sformatf("vecA%0d", i));
        foreach (tbl_b[i]) apply(tbl_b[i], 1'b1, $sformatf("vecB%0d", i));

        // Starvation: data writes and fetch both held; fetch forced every 5th issue.
        @(negedge clk);
        reset = 1; if_req = 0; d_req = 0;
        @(negedge clk);
        reset = 0;
        nd = 0; ni = 0; pat = '0;
        for (int c = 0; c < 80 && nd < 10; c++) begin
            @(negedge clk);
            if_req = 1; if_addr = 32'h400;
            d_req = 1; d_we = 1; d_addr = 32'(nd * 4); d_wdata = 32'(nd);
            #1;
            if (if_gnt_a) begin
                if (ni < 12) pat[ni] = 1'b1;
                ni++;
            end else if (d_gnt_a) begin
                ni++; nd++;
            end
        end
        chk_int("starve_issues", ni, 12);
        chk_int("starve_pattern", int'(pat), 32'h210);
        chk_int("starve_writes", nd, 10);

        // Randomized run against the reference model.
        m_cyc = 0; m_free = 0; m_done = -1; m_starve = 0;
        m_own_if = 0; m_we = 0; m_addr = 0;
        prev = '0;
        if_req = 0; d_req = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = (c == 0) || ($urandom_range(0, 199) == 0);
            if (prev.if_gnt) if_req = 0;
            if (prev.d_gnt) d_req = 0;
            if (!if_req) begin
                if ($urandom_range(0, 1) == 1) begin
                    if_req = 1; if_addr = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 0;
            end
            if (!d_req) begin
                if ($urandom_range(0, 1) == 1) begin
                    d_req = 1; d_we = 1'($urandom_range(0, 1));
                    d_addr = $urandom; d_wdata = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                d_req = 0;
            end
            #1;
            model_cycle(e);
            chk($sformatf("rand%0d", c), obs_a, e);
            prev = e;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
